// File: rtl/mem_arbiter.sv
// mem_arbiter: LS-priority IF/LS arbiter with IF anti-starvation; req valid/ready in, 1-cycle rsp pulses out, ram_rd_*/ram_wr_* to the RAM port
module mem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              ls_req_valid,
  input  logic              ls_req_we,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic [DATA_W-1:0] ls_req_wdata,
  input  logic [DATA_W-1:0] ls_req_wmask,
  output logic              ls_req_ready,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_data,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic [DATA_W-1:0] ram_wr_mask
);
  typedef enum logic {IDLE, RD_WAIT} state_t;
  state_t            state_q, state_d;
  logic [2:0]        lat_q, lat_d;
  logic [3:0]        starve_q, starve_d;
  logic              owner_q, owner_d;
  logic              if_rsp_valid_q, if_rsp_valid_d, ls_rsp_valid_q, ls_rsp_valid_d;
  logic [DATA_W-1:0] if_rsp_data_q, if_rsp_data_d, ls_rsp_data_q, ls_rsp_data_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d, wr_mask_q, wr_mask_d;
  logic              idle, starved, rd_acc, wr_acc, done;
  always_comb begin
    idle         = rst && state_q == IDLE;
    starved      = if_req_valid && starve_q == 4'(STARVE_MAX);
    ls_req_ready = idle && ls_req_valid && !starved;
    if_req_ready = idle && if_req_valid && !ls_req_ready;
    rd_acc       = if_req_ready || (ls_req_ready && !ls_req_we);
    wr_acc       = ls_req_ready && ls_req_we;
    done         = state_q == RD_WAIT && lat_q == 3'd1;
    rd_addr_d    = rd_acc ? (if_req_ready ? if_req_addr : ls_req_addr) : rd_addr_q;
    wr_addr_d    = wr_acc ? ls_req_addr : wr_addr_q;
    wr_data_d    = wr_acc ? ls_req_wdata : wr_data_q;
    wr_mask_d    = wr_acc ? ls_req_wmask : wr_mask_q;
    state_d      = rd_acc ? RD_WAIT : done ? IDLE : state_q;
    lat_d        = rd_acc ? 3'(RD_LAT) : state_q == RD_WAIT ? lat_q - 3'd1 : lat_q;
    owner_d      = rd_acc ? ls_req_ready : owner_q;
    // RD_WAIT holds the count; only an IDLE loss to LS advances it
    starve_d     = (!if_req_valid || if_req_ready) ? 4'd0 :
                   (ls_req_ready && !starved) ? starve_q + 4'd1 : starve_q;
    if_rsp_valid_d = done && !owner_q;
    ls_rsp_valid_d = (done && owner_q) || wr_acc;
    if_rsp_data_d  = (done && !owner_q) ? ram_rd_data : if_rsp_data_q;
    ls_rsp_data_d  = (done && owner_q) ? ram_rd_data : wr_acc ? '0 : ls_rsp_data_q;
    ram_rd_en      = rd_acc;
    ram_rd_addr    = rd_addr_d;
    ram_wr_en      = wr_acc;
    ram_wr_addr    = wr_addr_d;
    ram_wr_data    = wr_data_d;
    ram_wr_mask    = wr_mask_d;
    if_rsp_valid   = if_rsp_valid_q;
    if_rsp_data    = if_rsp_data_q;
    ls_rsp_valid   = ls_rsp_valid_q;
    ls_rsp_data    = ls_rsp_data_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      lat_q          <= '0;
      starve_q       <= '0;
      owner_q        <= 1'b0;
      if_rsp_valid_q <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= '0;
      ls_rsp_data_q  <= '0;
      rd_addr_q      <= '0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      wr_mask_q      <= '0;
    end else begin
      state_q        <= state_d;
      lat_q          <= lat_d;
      starve_q       <= starve_d;
      owner_q        <= owner_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      ls_rsp_valid_q <= ls_rsp_valid_d;
      if_rsp_data_q  <= if_rsp_data_d;
      ls_rsp_data_q  <= ls_rsp_data_d;
      rd_addr_q      <= rd_addr_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      wr_mask_q      <= wr_mask_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter with RD_LAT=1 (u1) and RD_LAT=3 (u3)
module tb_mem_arbiter;
  logic        clk = 0, rst = 0;
  logic        if_req_valid = 0, ls_req_valid = 0, ls_req_we = 0;
  logic [63:0] if_req_addr = 0, ls_req_addr = 0, ls_req_wdata = 0, ls_req_wmask = 0, ram_rd_data = 0;
  logic        if_req_ready, if_rsp_valid, ls_req_ready, ls_rsp_valid, ram_rd_en, ram_wr_en;
  logic [63:0] if_rsp_data, ls_rsp_data, ram_rd_addr, ram_wr_addr, ram_wr_data, ram_wr_mask;
  logic        if_req_ready_3, if_rsp_valid_3, ls_req_ready_3, ls_rsp_valid_3, ram_rd_en_3, ram_wr_en_3;
  logic [63:0] if_rsp_data_3, ls_rsp_data_3, ram_rd_addr_3, ram_wr_addr_3, ram_wr_data_3, ram_wr_mask_3;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  mem_arbiter #(.RD_LAT(1), .STARVE_MAX(4)) u1 (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_we(ls_req_we), .ls_req_addr(ls_req_addr),
    .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask), .ls_req_ready(ls_req_ready),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .ram_wr_mask(ram_wr_mask)
  );
  mem_arbiter #(.RD_LAT(3), .STARVE_MAX(4)) u3 (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready_3),
    .if_rsp_valid(if_rsp_valid_3), .if_rsp_data(if_rsp_data_3),
    .ls_req_valid(ls_req_valid), .ls_req_we(ls_req_we), .ls_req_addr(ls_req_addr),
    .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask), .ls_req_ready(ls_req_ready_3),
    .ls_rsp_valid(ls_rsp_valid_3), .ls_rsp_data(ls_rsp_data_3),
    .ram_rd_en(ram_rd_en_3), .ram_rd_addr(ram_rd_addr_3), .ram_rd_data(ram_rd_data),
    .ram_wr_en(ram_wr_en_3), .ram_wr_addr(ram_wr_addr_3), .ram_wr_data(ram_wr_data_3), .ram_wr_mask(ram_wr_mask_3)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    if_req_valid = 1; ls_req_valid = 1; ls_req_we = 1;
    for (int i = 0; i < 3; i++) begin
      step;
      check("rst_rdy", {if_req_ready, ls_req_ready}, 0);
      check("rst_en", {ram_rd_en, ram_wr_en}, 0);
      check("rst_rsp", {if_rsp_valid, ls_rsp_valid}, 0);
    end
    rst = 1; #1;
    check("rel_ls_rdy", ls_req_ready, 1);
    check("rel_if_rdy", if_req_ready, 0);
    check("rel_wr_en", ram_wr_en, 1);
    step;
    if_req_valid = 0; ls_req_valid = 0; #1;
    check("rel_ack", ls_rsp_valid, 1);
    step;
    if_req_valid = 1; if_req_addr = 64'h8000_0000; #1;
    check("if_rdy", if_req_ready, 1);
    check("if_rd_en", ram_rd_en, 1);
    check("if_rd_addr", ram_rd_addr, 64'h8000_0000);
    step;
    if_req_valid = 0; ram_rd_data = 64'h13; #1;
    check("if_wait_en", ram_rd_en, 0);
    check("if_wait_rsp", if_rsp_valid, 0);
    step;
    ram_rd_data = 64'h0; #1;
    check("if_rsp_v", if_rsp_valid, 1);
    check("if_rsp_d", if_rsp_data, 64'h13);
    check("if_ls_rsp", ls_rsp_valid, 0);
    step;
    if_req_valid = 1; if_req_addr = 64'h200; ls_req_valid = 1; ls_req_we = 0; ls_req_addr = 64'h100; #1;
    check("col_ls_rdy", ls_req_ready, 1);
    check("col_if_rdy", if_req_ready, 0);
    check("col_rd_addr", ram_rd_addr, 64'h100);
    step;
    ls_req_valid = 0; ram_rd_data = 64'hAAAA; #1;
    check("col_wait_if", if_req_ready, 0);
    step;
    #1;
    check("col_ls_rsp", ls_rsp_valid, 1);
    check("col_ls_data", ls_rsp_data, 64'hAAAA);
    check("col_if_rdy2", if_req_ready, 1);
    check("col_rd_addr2", ram_rd_addr, 64'h200);
    step;
    if_req_valid = 0; ram_rd_data = 64'hBBBB;
    step;
    check("col_if_rsp", if_rsp_valid, 1);
    check("col_if_data", if_rsp_data, 64'hBBBB);
    check("col_ls_quiet", ls_rsp_valid, 0);
    ls_req_valid = 1; ls_req_we = 1; if_req_valid = 1; #1;
    for (int i = 0; i < 4; i++) begin
      check("stv_ls_rdy", ls_req_ready, 1);
      check("stv_if_rdy", if_req_ready, 0);
      step;
    end
    check("stv_if_win", if_req_ready, 1);
    check("stv_ls_lose", ls_req_ready, 0);
    check("stv_ls_ack", ls_rsp_valid, 1);
    step;
    check("stv_wait", {if_req_ready, ls_req_ready}, 0);
    step;
    check("stv_if_rsp", if_rsp_valid, 1);
    check("stv_clr_ls", ls_req_ready, 1);
    check("stv_clr_if", if_req_ready, 0);
    step;
    if_req_valid = 0; ls_req_valid = 0; ram_rd_data = 0;
    step;
    step;
    ls_req_valid = 1; ls_req_we = 1; ls_req_addr = 64'h8000_1000;
    ls_req_wdata = 64'hDEAD_BEEF; ls_req_wmask = 64'hFFFF_FFFF; #1;
    check("wr_en", ram_wr_en, 1);
    check("wr_addr", ram_wr_addr, 64'h8000_1000);
    check("wr_data", ram_wr_data, 64'hDEAD_BEEF);
    check("wr_mask", ram_wr_mask, 64'hFFFF_FFFF);
    check("wr_no_rd", ram_rd_en, 0);
    step;
    ls_req_valid = 0; ls_req_addr = 0; #1;
    check("wr_ack", ls_rsp_valid, 1);
    check("wr_ack_d", ls_rsp_data, 0);
    check("wr_en_off", ram_wr_en, 0);
    check("wr_addr_hold", ram_wr_addr, 64'h8000_1000);
    rst = 0;
    step;
    rst = 1; if_req_valid = 1; if_req_addr = 64'h40; #1;
    check("mr_if_rdy", if_req_ready_3, 1);
    step;
    if_req_valid = 0; rst = 0;
    step;
    rst = 1; ls_req_valid = 1; ls_req_we = 1; #1;
    check("mr_ls_rdy", ls_req_ready_3, 1);
    step;
    ls_req_valid = 0;
    for (int i = 0; i < 6; i++) begin
      check("mr_no_rsp", if_rsp_valid_3, 0);
      step;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
